// File: rtl/conv_encoder_sweep_if.sv
// Handshake and output bundle between the encoder and its
// data source / branch metric consumer.
interface conv_encoder_sweep_if;
  logic        i_start;
  logic [1:0]  i_data;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [15:0] o_mux;
  logic        o_sweep_en;
  logic [5:0]  o_code;
  logic        o_code_valid;
  logic        o_tail;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_start, i_data, i_valid, i_last,
    input  o_ready, o_mux, o_sweep_en, o_code,
    input  o_code_valid, o_tail, o_busy, o_done
  );

  modport slave (
    input  i_start, i_data, i_valid, i_last,
    output o_ready, o_mux, o_sweep_en, o_code,
    output o_code_valid, o_tail, o_busy, o_done
  );
endinterface

// File: rtl/conv_encoder_sweep.sv
// Radix-4 convolutional encoder: one-time trellis sweep for the
// branch metric table, then framed encoding with a zero tail.
module conv_encoder_sweep #(
  parameter logic [9:0] G0 = 10'h2DB,
  parameter logic [9:0] G1 = 10'h3A5,
  parameter logic [9:0] G2 = 10'h26F,
  parameter logic [9:0] G3 = 10'h31D,
  parameter logic [9:0] G4 = 10'h2B3,
  parameter logic [9:0] G5 = 10'h3C9
) (
  input logic clk,
  input logic rst,
  conv_encoder_sweep_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SWEEP, ENCODE, FLUSH, DONE
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  st_q, st_d;
  logic        swept_q, swept_d;
  logic [1:0]  fl_q, fl_d;
  logic [15:0] mux_q, mux_d;
  logic        sen_q, sen_d;
  logic [5:0]  code_q, code_d;
  logic        cv_q, cv_d;
  logic        tail_q, tail_d;
  logic        step;

  function automatic logic [5:0] enc(
    input logic [1:0] in,
    input logic [7:0] st
  );
    logic [9:0] v;
    v = {in, st};
    return {^(G5 & v), ^(G4 & v), ^(G3 & v),
            ^(G2 & v), ^(G1 & v), ^(G0 & v)};
  endfunction

  assign bus.o_ready      = (fsm_q == ENCODE);
  assign bus.o_busy       = (fsm_q != IDLE);
  assign bus.o_done       = (fsm_q == DONE);
  assign bus.o_mux        = mux_q;
  assign bus.o_sweep_en   = sen_q;
  assign bus.o_code       = code_q;
  assign bus.o_code_valid = cv_q;
  assign bus.o_tail       = tail_q;

  assign step = bus.i_valid && (fsm_q == ENCODE);

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = 10'd0;
    st_d    = st_q;
    swept_d = swept_q;
    fl_d    = fl_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    tail_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (bus.i_start)
          fsm_d = swept_q ? ENCODE : SWEEP;
      end
      SWEEP: begin
        if (cnt_q == 10'h3FF) begin
          swept_d = 1'b1;
          fsm_d   = ENCODE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ENCODE: begin
        if (step) begin
          code_d = enc(bus.i_data, st_q);
          cv_d   = 1'b1;
          st_d   = {bus.i_data, st_q[7:2]};
          if (bus.i_last) begin
            fsm_d = FLUSH;
            fl_d  = 2'd0;
          end
        end
      end
      FLUSH: begin
        code_d = enc(2'b00, st_q);
        cv_d   = 1'b1;
        tail_d = 1'b1;
        st_d   = {2'b00, st_q[7:2]};
        fl_d   = fl_q + 2'd1;
        if (fl_q == 2'd3)
          fsm_d = DONE;
      end
      DONE: begin
        st_d  = 8'h00;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    // sweep word is registered so it lines up with o_sweep_en
    sen_d = (fsm_d == SWEEP);
    mux_d = sen_d ? {cnt_d, enc(cnt_d[9:8], cnt_d[7:0])}
                  : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= 10'd0;
      st_q    <= 8'h00;
      swept_q <= 1'b0;
      fl_q    <= 2'd0;
      mux_q   <= 16'h0000;
      sen_q   <= 1'b0;
      code_q  <= 6'h00;
      cv_q    <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      swept_q <= swept_d;
      fl_q    <= fl_d;
      mux_q   <= mux_d;
      sen_q   <= sen_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder_sweep.sv
// Scoreboard bench for conv_encoder_sweep: sweep, frames,
// mid-sweep reset and ignored handshakes.
module tb_conv_encoder_sweep;

  logic clk = 1'b0;
  logic rst;
  int   ntests = 0;
  int   nfail  = 0;
  int   sw_n   = 0;
  int   ndone  = 0;
  logic [6:0] q[$];

  conv_encoder_sweep_if bus();

  conv_encoder_sweep dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    while (!bus.o_done && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, bus.o_done}, 32'd1);
  endtask

  // codeword scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.o_code_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_code", {26'd0, bus.o_code},
            32'hFFFF_FFFF);
      end else begin
        logic [6:0] e;
        e = q.pop_front();
        chk("code", {25'd0, bus.o_tail, bus.o_code},
            {25'd0, e});
      end
    end
  end

  // sweep monitor with hand-computed spot entries
  always @(negedge clk) begin
    if (bus.o_sweep_en) begin
      logic [15:0] e;
      chk("sweep_cnt", {22'd0, bus.o_mux[15:6]},
          sw_n & 32'h3FF);
      e = 16'h0000;
      case (sw_n)
        0:      e = 16'h0000;
        1:      e = 16'h007F;
        'h100:  e = 16'h402A;
        'h200:  e = 16'h803F;
        'h3FF:  e = 16'hFFC5;
        default: e = bus.o_mux;
      endcase
      if (sw_n == 0 || sw_n == 1 || sw_n == 'h100 ||
          sw_n == 'h200 || sw_n == 'h3FF)
        chk("sweep_word", {16'd0, bus.o_mux}, {16'd0, e});
      sw_n++;
    end
  end

  always @(negedge clk) begin
    if (bus.o_done) ndone++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [1:0] fd [3] = '{2'b01, 2'b11, 2'b10};
  logic [5:0] fc [3] = '{6'h0F, 6'h29, 6'h3E};
  logic [5:0] ft [4] = '{6'h0D, 6'h0A, 6'h07, 6'h15};
  logic [5:0] gt [4] = '{6'h25, 6'h19, 6'h0E, 6'h3F};

  initial begin
    int n;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_data  = 2'b00;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    repeat (3) tick();
    chk("reset_outs",
        {3'd0, bus.o_ready, bus.o_mux, bus.o_sweep_en,
         bus.o_code, bus.o_code_valid, bus.o_tail,
         bus.o_busy, bus.o_done}, 32'd0);
    rst = 1'b0;
    tick();

    // aborted sweep
    sw_n = 0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    n = 0;
    while (!(bus.o_sweep_en && bus.o_mux[15:6] == 10'h155)
           && n < 2000) begin
      tick();
      n++;
    end
    chk("reach_155", {22'd0, bus.o_mux[15:6]}, 32'h155);
    rst = 1'b1;
    tick();
    chk("rst_mid_sweep",
        {3'd0, bus.o_ready, bus.o_mux, bus.o_sweep_en,
         bus.o_code, bus.o_code_valid, bus.o_tail,
         bus.o_busy, bus.o_done}, 32'd0);
    rst = 1'b0;
    tick();

    // full sweep
    sw_n = 0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("sweep_first", {16'd0, bus.o_mux}, 32'd0);
    n = 0;
    while (bus.o_sweep_en && n < 1100) begin
      tick();
      n++;
    end
    chk("sweep_len", sw_n, 1024);
    chk("mux_clear", {16'd0, bus.o_mux}, 32'd0);
    chk("ready_after_sweep", {31'd0, bus.o_ready}, 32'd1);

    // single step from state 0
    bus.i_data  = 2'b01;
    bus.i_valid = 1'b1;
    q.push_back({1'b0, 6'h2A});
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();

    // three-symbol frame from state 8'h40
    for (int i = 0; i < 3; i++) begin
      bus.i_data  = fd[i];
      bus.i_valid = 1'b1;
      bus.i_last  = (i == 2);
      q.push_back({1'b0, fc[i]});
      if (i == 2)
        for (int k = 0; k < 4; k++)
          q.push_back({1'b1, ft[k]});
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    chk("ready_in_flush", {31'd0, bus.o_ready}, 32'd0);
    wait_done("done_frame1");
    tick();
    chk("done_pulse1", {31'd0, bus.o_done}, 32'd0);
    chk("busy_idle1", {31'd0, bus.o_busy}, 32'd0);
    chk("drained1", q.size(), 0);

    // valid held in IDLE, then restart without sweep
    bus.i_data  = 2'b11;
    bus.i_valid = 1'b1;
    tick();
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("no_resweep", {31'd0, bus.o_sweep_en}, 32'd0);
    chk("ready_restart", {31'd0, bus.o_ready}, 32'd1);
    bus.i_data = 2'b01;
    bus.i_last = 1'b1;
    q.push_back({1'b0, 6'h2A});
    for (int k = 0; k < 4; k++)
      q.push_back({1'b1, gt[k]});
    tick();
    bus.i_data = 2'b11;
    bus.i_last = 1'b0;
    wait_done("done_frame2");
    tick();
    chk("done_pulse2", {31'd0, bus.o_done}, 32'd0);
    chk("busy_idle2", {31'd0, bus.o_busy}, 32'd0);
    bus.i_valid = 1'b0;
    repeat (3) tick();
    chk("drained2", q.size(), 0);
    chk("sweep_total", sw_n, 1024);
    chk("done_count", ndone, 2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
